// File: rtl/counter_up_mod.sv
// Programmable-modulus up counter with one-shot / continuous run control.
// Emits a registered terminal-count pulse and a saturating wrap tally.
module counter_up_mod #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ena,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] result,
  output logic         tc,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] wraps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] ALL_ONES = '1;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] result_d;
  logic [N-1:0] wraps_d;
  logic         tc_d;
  logic         mode_q;
  logic         mode_d;
  logic         at_max;
  logic         wrap_sat;
  logic         counting;

  assign at_max   = (result == max_val);
  assign wrap_sat = (wraps == ALL_ONES);
  assign counting = (state_q == COUNT) && ena;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      result  <= '0;
      tc      <= 1'b0;
      wraps   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      result  <= result_d;
      tc      <= tc_d;
      wraps   <= wraps_d;
      mode_q  <= mode_d;
    end
  end

  // Controls overlap, so first match wins: load > stop > start > count.
  always_comb begin
    state_d  = state_q;
    result_d = result;
    wraps_d  = wraps;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    priority case (1'b1)
      load: begin
        result_d = load_val;
      end
      stop: begin
        state_d = IDLE;
      end
      start: begin
        state_d  = COUNT;
        result_d = '0;
        wraps_d  = '0;
        mode_d   = oneshot;
      end
      default: begin
        if (counting) begin
          if (at_max) begin
            tc_d = 1'b1;
            if (mode_q) begin
              state_d = DONE;
            end else begin
              result_d = '0;
              if (!wrap_sat) begin
                wraps_d = wraps + 1'b1;
              end
            end
          end else begin
            // Above max_val the natural 2^N rollover is silent.
            result_d = result + 1'b1;
          end
        end
      end
    endcase
  end

  assign busy = (state_q == COUNT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_counter_up_mod.sv
// Directed and randomized bench for counter_up_mod.
// Outputs are compared every cycle against an arithmetic reference model.
module tb_counter_up_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] max_val;
  logic [7:0] result;
  logic       tc;
  logic       busy;
  logic       done;
  logic [7:0] wraps;

  counter_up_mod #(.N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .start    (start),
    .stop     (stop),
    .oneshot  (oneshot),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .result   (result),
    .tc       (tc),
    .busy     (busy),
    .done     (done),
    .wraps    (wraps)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  // reference model: 0 idle, 1 counting, 2 finished
  int m_st;
  int m_res;
  int m_wraps;
  int m_tc;
  int m_one;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_edge();
    int mx;
    mx = int'(max_val);
    m_tc = 0;
    if (reset) begin
      m_st = 0; m_res = 0; m_wraps = 0; m_one = 0;
    end else if (load) begin
      m_res = int'(load_val);
    end else if (stop) begin
      m_st = 0;
    end else if (start) begin
      m_st = 1; m_res = 0; m_wraps = 0; m_one = int'(oneshot);
    end else if (m_st == 1 && ena) begin
      if (m_res == mx) begin
        m_tc = 1;
        if (m_one == 1) m_st = 2;
        else begin
          m_res = 0;
          m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
        end
      end else begin
        m_res = (m_res + 1) % 256;
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, ".result"}, 32'(result), 32'(m_res));
    chk({tag, ".tc"},     32'(tc),     32'(m_tc));
    chk({tag, ".busy"},   32'(busy),   32'(m_st == 1));
    chk({tag, ".done"},   32'(done),   32'(m_st == 2));
    chk({tag, ".wraps"},  32'(wraps),  32'(m_wraps));
  endtask

  task automatic idle_in();
    reset = 0; ena = 0; start = 0; stop = 0;
    oneshot = 0; load = 0; load_val = 0;
  endtask

  initial begin
    int exp_res[8];
    int exp_tc[8];
    idle_in();
    max_val = 0;
    m_st = 0; m_res = 0; m_wraps = 0; m_tc = 0; m_one = 0;

    // reset for two cycles, then idle
    reset = 1;
    cyc("rst0");
    cyc("rst1");
    reset = 0;
    cyc("idle");
    chk("rst.result", 32'(result), 0);
    chk("rst.busy",   32'(busy),   0);
    chk("rst.wraps",  32'(wraps),  0);

    // reset mid-count at result 5
    max_val = 9; start = 1; ena = 1;
    cyc("mid.start");
    start = 0;
    for (int i = 0; i < 5; i++) cyc("mid.cnt");
    chk("mid.at5", 32'(result), 5);
    reset = 1;
    cyc("mid.rst");
    reset = 0;
    chk("mid.rst.result", 32'(result), 0);
    chk("mid.rst.busy",   32'(busy),   0);
    chk("mid.rst.tc",     32'(tc),     0);

    // continuous, max 3
    exp_res = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_tc  = '{0, 0, 0, 1, 0, 0, 0, 1};
    max_val = 3; oneshot = 0; start = 1; ena = 1;
    cyc("cont.start");
    start = 0;
    chk("cont.r0", 32'(result), 0);
    for (int i = 0; i < 8; i++) begin
      cyc("cont");
      chk($sformatf("cont.r%0d", i), 32'(result), 32'(exp_res[i]));
      chk($sformatf("cont.tc%0d", i), 32'(tc), 32'(exp_tc[i]));
    end
    chk("cont.wraps", 32'(wraps), 2);

    // one-shot, max 4
    max_val = 4; oneshot = 1; start = 1;
    cyc("os.start");
    start = 0; oneshot = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc("os");
      chk($sformatf("os.r%0d", i), 32'(result), 32'(i));
    end
    cyc("os.term");
    chk("os.tc",   32'(tc),   1);
    chk("os.done", 32'(done), 1);
    for (int i = 0; i < 10; i++) cyc("os.hold");
    chk("os.hold.result", 32'(result), 4);
    chk("os.hold.busy",   32'(busy),   0);

    // ena toggling, max 9
    max_val = 9; start = 1; ena = 1;
    cyc("ena.start");
    start = 0;
    for (int i = 0; i < 4; i++) begin
      ena = (i % 2 == 0);
      cyc("ena");
      chk($sformatf("ena.r%0d", i), 32'(result), 32'((i / 2) + 1));
      chk($sformatf("ena.tc%0d", i), 32'(tc), 0);
    end

    // load above max: silent rollover, tc only on 5 -> 0
    max_val = 5; ena = 1; load = 1; load_val = 250;
    cyc("ld");
    load = 0;
    chk("ld.result", 32'(result), 250);
    for (int i = 0; i < 12; i++) begin
      cyc("ld.run");
      chk($sformatf("ld.tc%0d", i), 32'(tc), 32'(i == 11));
    end
    chk("ld.end", 32'(result), 0);

    // load + start + stop in one cycle
    load = 1; load_val = 7; start = 1; stop = 1; ena = 0;
    cyc("mix");
    chk("mix.result", 32'(result), 7);
    chk("mix.busy",   32'(busy),   1);
    load = 0; stop = 0;
    cyc("mix.start");
    start = 0;
    chk("mix.start.result", 32'(result), 0);
    chk("mix.start.wraps",  32'(wraps),  0);

    // max 0 continuous: tc each cycle, wraps saturates
    max_val = 0; start = 1; ena = 1;
    cyc("z.start");
    start = 0;
    for (int i = 0; i < 260; i++) cyc("z");
    chk("z.tc",    32'(tc),    1);
    chk("z.wraps", 32'(wraps), 255);

    // randomized
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 99) < 3);
      stop     = ($urandom_range(0, 99) < 3);
      start    = ($urandom_range(0, 99) < 6);
      oneshot  = 1'($urandom_range(0, 1));
      ena      = ($urandom_range(0, 9) < 8);
      load_val = 8'($urandom);
      if ($urandom_range(0, 19) == 0) max_val = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) max_val = 8'($urandom_range(0, 7));
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
